// File: rtl/o_line_fetch_scheduler_if.sv
// Framebuffer burst-read port between the line fetch scheduler and memory.
// The scheduler is the master; the memory controller is the slave.
interface o_line_fetch_scheduler_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/o_line_fetch_scheduler.sv
// Framebuffer-to-linebuffer fetch sequencer with ping-pong banks and underrun flag.
// Optional saturating underrun counter: define O_LINE_FETCH_STATS_EN.
module o_line_fetch_scheduler #(
    parameter int LB_ADDR_WIDTH  = 9,
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int BURST_LEN      = 16
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     req_frame,
    input  logic                     req_line,
    input  logic [31:0]              fb_base,
    o_line_fetch_scheduler_if.master mem,
    output logic                     lb_we,
    output logic [LB_ADDR_WIDTH-1:0] lb_addr,
    output logic [31:0]              lb_wdata,
    output logic                     display_bank,
    output logic                     busy,
    output logic                     underrun,
    input  logic                     underrun_clr,
    output logic [15:0]              underrun_count
);
    localparam int WORDS_PER_LINE  = DISPLAY_WIDTH / 4;
    localparam int BURSTS_PER_LINE = WORDS_PER_LINE / BURST_LEN;
    localparam int IW = LB_ADDR_WIDTH - 1;
    localparam int LW = $clog2(DISPLAY_HEIGHT + 1);
    localparam int BW = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
    localparam int TW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [LW-1:0] LAST_LINE  = LW'(DISPLAY_HEIGHT);
    localparam logic [BW-1:0] LAST_BURST = BW'(BURSTS_PER_LINE - 1);
    localparam logic [TW-1:0] LAST_BEAT  = TW'(BURST_LEN - 1);
    localparam logic [31:0]   WPL32      = 32'(WORDS_PER_LINE);
    localparam logic [31:0]   BL32       = 32'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     line_q, line_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [TW-1:0]     beat_q, beat_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       pbase_q, pbase_d;
    logic              pend_frame_q, pend_frame_d;
    logic              pend_line_q, pend_line_d;
    logic              disp_q, disp_d;
    logic              under_q, under_d;
    logic              we_q, we_d;
    logic [LB_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              frame_ev, line_ev, busy_w, ur_ev;
    logic              do_frame, do_fetch;
    logic [LW-1:0]     line_inc;
    logic [31:0]       offset;

    assign frame_ev = req_frame;
    assign line_ev  = req_line & ~req_frame;
    assign busy_w   = (state_q != IDLE);
    assign ur_ev    = line_ev & busy_w;
    assign line_inc = line_q + 1'b1;
    assign offset   = (32'(line_q) * WPL32 + 32'(burst_q) * BL32) << 2;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        widx_d       = widx_q;
        base_d       = base_q;
        pbase_d      = (frame_ev & busy_w) ? fb_base : pbase_q;
        pend_frame_d = pend_frame_q | (frame_ev & busy_w);
        pend_line_d  = pend_line_q | ur_ev;
        disp_d       = disp_q;
        under_d      = ur_ev ? 1'b1 : (underrun_clr ? 1'b0 : under_q);
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        do_frame     = 1'b0;
        do_fetch     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_ev) begin
                    do_frame = 1'b1;
                end else if (line_ev) begin
                    disp_d   = ~disp_q;
                    do_fetch = (line_q < LAST_LINE);
                end
            end
            REQ: begin
                if (mem.rd_ack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (mem.rd_valid) begin
                    we_d    = 1'b1;
                    wdata_d = mem.rd_data;
                    waddr_d = {~disp_q, widx_q};
                    widx_d  = widx_q + 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        // A pending frame restart cuts the line short at a burst boundary.
                        if (burst_q == LAST_BURST || pend_frame_d) begin
                            state_d = DONE;
                        end else begin
                            burst_d = burst_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end
            end
            DONE: begin
                line_d  = line_inc;
                state_d = IDLE;
                if (pend_frame_d) begin
                    do_frame = 1'b1;
                end else if (pend_line_d) begin
                    pend_line_d = 1'b0;
                    disp_d      = ~disp_q;
                    do_fetch    = (line_inc != LAST_LINE);
                end
            end
        endcase

        if (do_frame) begin
            base_d       = (state_q == IDLE || frame_ev) ? fb_base : pbase_q;
            line_d       = '0;
            pend_frame_d = 1'b0;
            pend_line_d  = 1'b0;
            do_fetch     = 1'b1;
        end
        if (do_fetch) begin
            state_d = REQ;
            burst_d = '0;
            beat_d  = '0;
            widx_d  = '0;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            line_q       <= '0;
            burst_q      <= '0;
            beat_q       <= '0;
            widx_q       <= '0;
            base_q       <= '0;
            pbase_q      <= '0;
            pend_frame_q <= 1'b0;
            pend_line_q  <= 1'b0;
            disp_q       <= 1'b0;
            under_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            widx_q       <= widx_d;
            base_q       <= base_d;
            pbase_q      <= pbase_d;
            pend_frame_q <= pend_frame_d;
            pend_line_q  <= pend_line_d;
            disp_q       <= disp_d;
            under_q      <= under_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

`ifdef O_LINE_FETCH_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (underrun_clr) begin
            cnt_d = ur_ev ? 16'd1 : 16'd0;
        end else if (ur_ev && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign underrun_count = cnt_q;
`else
    assign underrun_count = 16'd0;
`endif

    assign mem.rd_req  = (state_q == REQ);
    assign mem.rd_addr = (state_q == REQ) ? base_q + offset : 32'd0;
    assign lb_we        = we_q;
    assign lb_addr      = waddr_q;
    assign lb_wdata     = wdata_q;
    assign display_bank = disp_q;
    assign busy         = busy_w;
    assign underrun     = under_q;
endmodule

// File: tb/tb_o_line_fetch_scheduler.sv
// Bench for o_line_fetch_scheduler: memory responder, transaction scoreboard
// and directed scenarios on a 64x4 display with 4-word bursts.
module tb_o_line_fetch_scheduler;
    localparam int LBW = 9;
    localparam int DW  = 64;
    localparam int DH  = 4;
    localparam int BL  = 4;
    localparam int WPL = DW / 4;
`ifdef O_LINE_FETCH_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic           pclk = 1'b0;
    logic           reset = 1'b1;
    logic           req_frame = 1'b0;
    logic           req_line = 1'b0;
    logic           underrun_clr = 1'b0;
    logic [31:0]    fb_base = 32'd0;
    logic           lb_we;
    logic [LBW-1:0] lb_addr;
    logic [31:0]    lb_wdata;
    logic           display_bank;
    logic           busy;
    logic           underrun;
    logic [15:0]    underrun_count;

    o_line_fetch_scheduler_if mem_if();

    o_line_fetch_scheduler #(
        .LB_ADDR_WIDTH (LBW),
        .DISPLAY_WIDTH (DW),
        .DISPLAY_HEIGHT(DH),
        .BURST_LEN     (BL)
    ) dut (
        .pclk          (pclk),
        .reset         (reset),
        .req_frame     (req_frame),
        .req_line      (req_line),
        .fb_base       (fb_base),
        .mem           (mem_if.master),
        .lb_we         (lb_we),
        .lb_addr       (lb_addr),
        .lb_wdata      (lb_wdata),
        .display_bank  (display_bank),
        .busy          (busy),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr),
        .underrun_count(underrun_count)
    );

    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    typedef struct {
        logic [LBW-1:0] a;
        logic [31:0]    d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_req[$];
    logic [31:0] last_ra = 32'd0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;

    // Word i of line ln lives at base + (ln*WPL + i)*4; memory echoes the address.
    task automatic model_line(input logic [31:0] base, input int ln,
                              input logic bank);
        for (int k = 0; k < WPL / BL; k++)
            exp_req.push_back(base + 32'((ln * WPL + k * BL) * 4));
        for (int i = 0; i < WPL; i++)
            exp_wr.push_back('{a: {bank, 8'(i)},
                               d: base + 32'((ln * WPL + i) * 4)});
    endtask

    always @(negedge pclk) begin
        if (!reset) begin
            if (lb_we) begin
                if (exp_wr.size() == 0) begin
                    chk("spurious lb_we", 32'(lb_we), 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("lb_addr", 32'(lb_addr), 32'(w.a));
                    chk("lb_wdata", lb_wdata, w.d);
                    last_wa = 32'(lb_addr);
                    last_wd = lb_wdata;
                end
            end
            if (mem_if.rd_req && mem_if.rd_ack) begin
                if (exp_req.size() == 0) begin
                    chk("spurious rd_req", 32'(mem_if.rd_req), 32'd0);
                end else begin
                    chk("rd_addr", mem_if.rd_addr, exp_req.pop_front());
                    last_ra = mem_if.rd_addr;
                end
            end
        end
    end

    int ack_dly  = 2;
    bit stab_chk = 1'b0;
    int mem_beat = 0;

    initial begin
        logic [31:0] a;
        mem_if.rd_ack   = 1'b0;
        mem_if.rd_valid = 1'b0;
        mem_if.rd_data  = 32'd0;
        forever begin
            @(posedge pclk); #1;
            if (mem_if.rd_req) begin
                a = mem_if.rd_addr;
                for (int i = 0; i < ack_dly; i++) begin
                    if (stab_chk) begin
                        chk("stall rd_req", 32'(mem_if.rd_req), 32'd1);
                        chk("stall rd_addr", mem_if.rd_addr, a);
                    end
                    @(posedge pclk); #1;
                end
                mem_if.rd_ack = 1'b1;
                @(posedge pclk); #1;
                mem_if.rd_ack = 1'b0;
                for (int i = 0; i < BL; i++) begin
                    mem_if.rd_valid = 1'b1;
                    mem_if.rd_data  = a + 32'(4 * i);
                    mem_beat        = i + 1;
                    @(posedge pclk); #1;
                end
                mem_if.rd_valid = 1'b0;
                mem_beat        = 0;
            end
        end
    end

    task automatic pulse(input logic f, input logic l, input logic c);
        @(posedge pclk); #1;
        req_frame    = f;
        req_line     = l;
        underrun_clr = c;
        @(posedge pclk); #1;
        req_frame    = 1'b0;
        req_line     = 1'b0;
        underrun_clr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge pclk);
            t++;
        end
        chk({nm, " busy timeout"}, 32'(busy), 32'd0);
        chk({nm, " writes left"}, 32'(exp_wr.size()), 32'd0);
        chk({nm, " reqs left"}, 32'(exp_req.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        logic [31:0] base;

        repeat (3) @(posedge pclk);
        #1;
        chk("rst rd_req", 32'(mem_if.rd_req), 32'd0);
        chk("rst rd_addr", mem_if.rd_addr, 32'd0);
        chk("rst lb_we", 32'(lb_we), 32'd0);
        chk("rst lb_addr", 32'(lb_addr), 32'd0);
        chk("rst lb_wdata", lb_wdata, 32'd0);
        chk("rst display_bank", 32'(display_bank), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst underrun", 32'(underrun), 32'd0);
        chk("rst count", 32'(underrun_count), 32'd0);
        reset = 1'b0;

        base = 32'h1000_0000;
        fb_base = base;
        model_line(base, 0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle("prefetch");
        chk("prefetch last req", last_ra, 32'h1000_0030);
        chk("prefetch last waddr", last_wa, 32'h0000_010F);
        chk("prefetch last wdata", last_wd, 32'h1000_003C);
        chk("prefetch bank", 32'(display_bank), 32'd0);

        model_line(base, 1, 1'b0);
        model_line(base, 2, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("swap bank", 32'(display_bank), 32'd1);
        t = 0;
        while (exp_wr.size() == 2 * WPL && t < 200) begin
            @(negedge pclk);
            t++;
        end
        chk("line1 first write", 32'(exp_wr.size()), 32'(2 * WPL - 1));
        pulse(1'b0, 1'b1, 1'b0);
        chk("underrun set", 32'(underrun), 32'd1);
        chk("count one", 32'(underrun_count), 32'(STATS));
        chk("no mid-fetch swap", 32'(display_bank), 32'd1);
        repeat (3) @(posedge pclk);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle("underrun");
        chk("underrun held", 32'(underrun), 32'd1);
        chk("count two", 32'(underrun_count), 32'(2 * STATS));
        chk("pending swap bank", 32'(display_bank), 32'd0);
        chk("line2 last req", last_ra, 32'h1000_00B0);
        chk("line2 last waddr", last_wa, 32'h0000_010F);

        model_line(base, 3, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("line3 bank", 32'(display_bank), 32'd1);
        wait_idle("line3");
        chk("line3 last wdata", last_wd, 32'h1000_00FC);
        chk("line3 last waddr", last_wa, 32'h0000_000F);

        pulse(1'b0, 1'b1, 1'b0);
        chk("eof bank", 32'(display_bank), 32'd0);
        repeat (5) @(negedge pclk);
        chk("eof busy", 32'(busy), 32'd0);
        chk("eof rd_req", 32'(mem_if.rd_req), 32'd0);
        chk("eof underrun", 32'(underrun), 32'd1);
        chk("eof count", 32'(underrun_count), 32'(2 * STATS));

        pulse(1'b0, 1'b0, 1'b1);
        chk("clr underrun", 32'(underrun), 32'd0);
        chk("clr count", 32'(underrun_count), 32'd0);

        base = 32'hFFFF_FFC0;
        fb_base = base;
        model_line(base, 0, 1'b1);
        pulse(1'b1, 1'b1, 1'b0);
        chk("restart bank", 32'(display_bank), 32'd0);
        wait_idle("restart");
        chk("restart underrun", 32'(underrun), 32'd0);
        chk("restart count", 32'(underrun_count), 32'd0);
        chk("restart last req", last_ra, 32'hFFFF_FFF0);
        chk("restart last wdata", last_wd, 32'hFFFF_FFFC);

        model_line(base, 1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle("wrap");
        chk("wrap last req", last_ra, 32'h0000_0030);
        chk("wrap last wdata", last_wd, 32'h0000_003C);
        chk("wrap bank", 32'(display_bank), 32'd1);

        ack_dly  = 10;
        stab_chk = 1'b1;
        model_line(base, 2, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle("backpressure");
        stab_chk = 1'b0;
        ack_dly  = 2;
        chk("bp last req", last_ra, 32'h0000_0070);

        base = 32'h3000_0000;
        fb_base = base;
        model_line(base, 0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        t = 0;
        while (mem_beat != 2 && t < 200) begin
            @(negedge pclk);
            t++;
        end
        chk("reach beat 2", 32'(mem_beat), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async rd_req", 32'(mem_if.rd_req), 32'd0);
        chk("async lb_we", 32'(lb_we), 32'd0);
        chk("async bank", 32'(display_bank), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        exp_wr.delete();
        exp_req.delete();
        @(posedge pclk); #1;
        reset = 1'b0;
        repeat (10) @(negedge pclk);
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset lb_we", 32'(lb_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/o_line_fetch_scheduler.md
Name: o_line_fetch_scheduler

Overview:
- Sequences framebuffer-to-linebuffer transfers for the video output path.
- Responds to the req_frame/req_line pulses from the output buffer controller and issues burst reads to the framebuffer memory port.
- Writes the returned words into a ping-pong linebuffer and selects which bank the display side reads.
- Flags underruns when the display requests a line that has not finished fetching.

Parameters:
- LB_ADDR_WIDTH, 9: linebuffer word-address width. MSB is the bank select; the remaining bits are the word index.
- DISPLAY_WIDTH, 640: pixels per line, 8-bit RAW, 4 pixels per 32-bit word. Must be a multiple of 4*BURST_LEN.
- DISPLAY_HEIGHT, 320: lines per frame.
- BURST_LEN, 16: words per memory read burst.
- Localparam WORDS_PER_LINE = DISPLAY_WIDTH/4. Localparam BURSTS_PER_LINE = WORDS_PER_LINE/BURST_LEN.

Ports:
- pclk  in  1  video pixel clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- req_frame  in  1  single-cycle pulse: new frame starting
- req_line  in  1  single-cycle pulse: display consumed current line
- fb_base  in  32  framebuffer byte base address; sampled on req_frame
- rd_req  out  1  burst read request
- rd_addr  out  32  burst start byte address
- rd_ack  in  1  memory accepts request when high together with rd_req
- rd_valid  in  1  read data beat valid
- rd_data  in  32  read data beat; first pixel in bits [31:24]
- lb_we  out  1  linebuffer write enable
- lb_addr  out  LB_ADDR_WIDTH  linebuffer write address {fill_bank, word_idx}
- lb_wdata  out  32  linebuffer write data
- display_bank  out  1  bank the display side reads
- busy  out  1  fetch in progress
- underrun  out  1  sticky underrun flag
- underrun_clr  in  1  clears underrun (and the counter)
- underrun_count  out  16  underrun event count

Behaviour:
- Reset values (async, applied immediately): all outputs 0; state IDLE; line index 0; base 0; pending flags 0. fill_bank is the inverse of display_bank, so it resets to 1.
- IDLE:
  - req_frame: latch fb_base, line=0, clear pending flags, go REQ (prefetch line 0 into fill bank).
  - req_line: toggle display_bank (fill_bank follows). If line < DISPLAY_HEIGHT, go REQ. Otherwise (frame fully fetched) stay IDLE, no underrun.
- REQ:
  - rd_req=1.
  - rd_addr = base + (line*WORDS_PER_LINE + burst*BURST_LEN)*4, computed 32-bit, wraps modulo 2^32.
  - rd_req and rd_addr stay stable until a cycle with rd_ack=1, then go DATA.
- DATA:
  - Each rd_valid beat is registered and appears as lb_we=1 one cycle later, with lb_wdata=rd_data and lb_addr={fill_bank, line word index}.
  - Word index runs 0..WORDS_PER_LINE-1 across the bursts.
  - After BURST_LEN beats: if more bursts remain in the line, go REQ; otherwise go DONE.
- DONE (one cycle):
  - line increments.
  - If pending_frame: apply req_frame actions.
  - Else if pending_line: clear it, toggle banks, go REQ (or IDLE if line == DISPLAY_HEIGHT).
  - Otherwise go IDLE.
- busy=1 in REQ, DATA and DONE.
- req_line while busy:
  - Set underrun, set pending_line.
  - No bank swap mid-fetch, no abort.
  - Further req_line while pending_line is already set: underrun count still increments; one-deep pending.
- req_frame while busy: set pending_frame; the current burst completes.
- Simultaneous req_frame and req_line: req_frame wins; req_line is ignored, with no underrun.
- rd_valid outside DATA is ignored; no lb_we.
- underrun_clr: takes effect next cycle. An underrun event in the same cycle wins (flag stays 1).
- Reset mid-burst: return to IDLE at once. The memory side is responsible for draining in-flight beats; those beats are ignored.

Optional Feature:
- Macro O_LINE_FETCH_STATS_EN.
- Defined: underrun_count is a 16-bit saturating counter (holds at 16'hFFFF), incremented per underrun event and cleared by reset or underrun_clr.
- Undefined: underrun_count is tied to 0 and no counter logic is built. The underrun flag is unaffected.

Test Plan:
- Setup for all scenarios: DISPLAY_WIDTH=64, DISPLAY_HEIGHT=4, BURST_LEN=4, so WORDS_PER_LINE=16.
- Frame prefetch:
  - Stimulus: fb_base=32'h1000_0000, req_frame; memory acks after 2 cycles and returns data=address.
  - Required: 4 requests at 0x1000_0000, 0x1000_0010, 0x1000_0020, 0x1000_0030; 16 writes to lb_addr 0x100..0x10F; busy drops.
- Line swap:
  - Stimulus: req_line after prefetch.
  - Required: display_bank 0->1 next cycle; line 1 fetched from 0x1000_0040 into lb_addr 0x000..0x00F.
- Underrun:
  - Stimulus: req_line while line 1 mid-burst, then a second req_line before completion.
  - Required: underrun=1 and underrun_count=2 (macro defined); a single swap occurs in DONE; line 2 fetch starts immediately after.
- End of frame:
  - Stimulus: fetch all 4 lines, then req_line.
  - Required: bank toggles, no rd_req, underrun unchanged.
- Frame restart and reset:
  - Stimulus: req_frame and req_line in the same cycle.
  - Required: line 0 refetched, no underrun.
  - Stimulus: assert reset during DATA beat 2.
  - Required: rd_req=0, lb_we=0, display_bank=0 within the same cycle; trailing rd_valid produces no write.
- Backpressure:
  - Stimulus: rd_ack held low 10 cycles.
  - Required: rd_req and rd_addr stable for all 10 cycles; exactly one burst accepted.
